// File: rtl/car_direction_detector.sv
// Gate-sensor front end: synchronises and debounces two beam sensors, tracks crossings, pulses entry/exit/err.
// Optional DIR_FULL_BLOCK_EN adds a full input that turns an entry completing while full into an error.
module car_direction_detector #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic sens_a,
    input  logic sens_b,
`ifdef DIR_FULL_BLOCK_EN
    input  logic full,
`endif
    output logic entry_pulse,
    output logic exit_pulse,
    output logic busy,
    output logic err_pulse
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_IN_A     = 3'd1;
    localparam logic [2:0] S_IN_AB    = 3'd2;
    localparam logic [2:0] S_IN_BL    = 3'd3;
    localparam logic [2:0] S_OUT_B    = 3'd4;
    localparam logic [2:0] S_OUT_BA   = 3'd5;
    localparam logic [2:0] S_OUT_AL   = 3'd6;
    localparam logic [2:0] S_WAIT_CLR = 3'd7;

    logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
    logic [1:0]             synced;
    logic [DBW-1:0]         db_cnt_q [2];
    logic [DBW-1:0]         db_cnt_d [2];
    logic [1:0]             filt_q, filt_d;
    logic [2:0]             state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   entry_q, entry_d;
    logic                   exit_q, exit_d;
    logic                   err_q, err_d;
    logic                   active;

    assign synced = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

    // Filtered level follows the synchronised one only after an unbroken run of differing samples.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (synced[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    filt_d[i] = synced[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    assign active = (state_q != S_IDLE) && (state_q != S_WAIT_CLR);

    always_comb begin
        state_d = state_q;
        entry_d = 1'b0;
        exit_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (filt_q == 2'b10)      state_d = S_IN_A;
                else if (filt_q == 2'b01) state_d = S_OUT_B;
                else if (filt_q == 2'b11) begin state_d = S_WAIT_CLR; err_d = 1'b1; end
            end
            S_IN_A: begin
                if (filt_q == 2'b11)      state_d = S_IN_AB;
                else if (filt_q == 2'b00) state_d = S_IDLE;
                else if (filt_q == 2'b01) begin state_d = S_WAIT_CLR; err_d = 1'b1; end
            end
            S_IN_AB: begin
                if (filt_q == 2'b01)      state_d = S_IN_BL;
                else if (filt_q == 2'b10) state_d = S_IN_A;
                else if (filt_q == 2'b00) begin state_d = S_WAIT_CLR; err_d = 1'b1; end
            end
            S_IN_BL: begin
                if (filt_q == 2'b00) begin
                    state_d = S_IDLE;
`ifdef DIR_FULL_BLOCK_EN
                    if (full) err_d = 1'b1;
                    else      entry_d = 1'b1;
`else
                    entry_d = 1'b1;
`endif
                end
                else if (filt_q == 2'b11) state_d = S_IN_AB;
                else if (filt_q == 2'b10) begin state_d = S_WAIT_CLR; err_d = 1'b1; end
            end
            S_OUT_B: begin
                if (filt_q == 2'b11)      state_d = S_OUT_BA;
                else if (filt_q == 2'b00) state_d = S_IDLE;
                else if (filt_q == 2'b10) begin state_d = S_WAIT_CLR; err_d = 1'b1; end
            end
            S_OUT_BA: begin
                if (filt_q == 2'b10)      state_d = S_OUT_AL;
                else if (filt_q == 2'b01) state_d = S_OUT_B;
                else if (filt_q == 2'b00) begin state_d = S_WAIT_CLR; err_d = 1'b1; end
            end
            S_OUT_AL: begin
                if (filt_q == 2'b00)      begin state_d = S_IDLE; exit_d = 1'b1; end
                else if (filt_q == 2'b11) state_d = S_OUT_BA;
                else if (filt_q == 2'b01) begin state_d = S_WAIT_CLR; err_d = 1'b1; end
            end
            default: begin
                if (filt_q == 2'b00) state_d = S_IDLE;
            end
        endcase

        // A crossing that sits in one state for TIMEOUT_CYCLES cycles is abandoned.
        if (active && (state_d == state_q) && (timer_q == TW'(TIMEOUT_CYCLES - 1))) begin
            state_d = S_WAIT_CLR;
            err_d   = 1'b1;
        end

        if (!active || (state_d != state_q)) timer_d = '0;
        else                                 timer_d = timer_q + TW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a_q    <= '0;
            sync_b_q    <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            filt_q      <= '0;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            entry_q     <= 1'b0;
            exit_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync_a_q    <= {sync_a_q[SYNC_STAGES-2:0], sens_a};
            sync_b_q    <= {sync_b_q[SYNC_STAGES-2:0], sens_b};
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            filt_q      <= filt_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            entry_q     <= entry_d;
            exit_q      <= exit_d;
            err_q       <= err_d;
        end
    end

    assign entry_pulse = entry_q;
    assign exit_pulse  = exit_q;
    assign err_pulse   = err_q;
    assign busy        = (state_q != S_IDLE);

endmodule
